man_demod: RTL and testbench

- Oversampling Manchester decoder on the RFID receive path.
- Consumes the raw Manchester line produced by the upstream modulator/front-end and recovers NRZ bits, one `out_valid` strobe per bit.
- Provides frame lock, error and end-of-frame indications to the downstream frame parser.
- Line convention: bit 1 = high-then-low (falling mid-bit edge); bit 0 = low-then-high (rising mid-bit edge).

---
 rtl/man_demod.sv | 139 +++++++++++++
 tb/tb_man_demod.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/man_demod.sv
// Oversampling Manchester decoder: recovers NRZ bits from a raw Manchester line and
// reports frame lock, timing errors and end-of-frame to the frame parser.
module man_demod #(
   parameter int unsigned OVS   = 8,
   parameter int unsigned CNT_W = 6
) (
   input  logic clk,
   input  logic in_enable,
   input  logic in_data,
   output logic out_data,
   output logic out_valid,
   output logic out_locked,
   output logic out_err,
   output logic out_eof
);

   localparam logic [CNT_W-1:0] CntMax    = CNT_W'(5 * OVS / 2 + 1);
   localparam logic [CNT_W-1:0] GlitchLim = CNT_W'(OVS / 2);
   localparam logic [CNT_W-1:0] ShortLim  = CNT_W'(3 * OVS / 2);
   localparam logic [CNT_W-1:0] LongMax   = CNT_W'(5 * OVS / 2);

   typedef enum logic [1:0] {StHunt, StMid, StBnd} state_e;

   state_e           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] cnt_q;
   logic             line_edge, line_rise;
   logic             is_glitch, is_short, is_long, timeout;
   logic             valid_d, err_d, eof_d, data_d;

   assign line_edge = s2_q ^ s3_q;
   assign line_rise = s2_q & ~s3_q;

   // cnt_q holds the number of clk cycles since the previous line edge
   assign is_glitch = (cnt_q < GlitchLim);
   assign is_short  = (cnt_q >= GlitchLim) && (cnt_q < ShortLim);
   assign is_long   = (cnt_q >= ShortLim) && (cnt_q <= LongMax);
   assign timeout   = (cnt_q == CntMax);

   always_ff @(posedge clk or negedge in_enable) begin
      if (!in_enable) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         s3_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q <= in_data;
         s2_q <= s1_q;
         s3_q <= s2_q;
         if (line_edge) begin
            cnt_q <= CNT_W'(1);
         end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge in_enable) begin
      if (!in_enable) begin
         state_q <= StHunt;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHunt: begin
            if (line_edge && is_long) state_d = StMid;
         end
         StMid: begin
            if (timeout) begin
               state_d = StHunt;
            end else if (line_edge) begin
               if (is_short)     state_d = StBnd;
               else if (is_long) state_d = StMid;
               else              state_d = StHunt;
            end
         end
         StBnd: begin
            if (timeout) begin
               state_d = StHunt;
            end else if (line_edge) begin
               if (is_short) state_d = StMid;
               else          state_d = StHunt;
            end
         end
         default: state_d = StHunt;
      endcase
   end

   always_comb begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      eof_d   = 1'b0;
      unique case (state_q)
         StHunt: begin
            if (line_edge && is_long) valid_d = 1'b1;
         end
         StMid: begin
            if (timeout) begin
               eof_d = 1'b1;
            end else if (line_edge) begin
               if (is_long)        valid_d = 1'b1;
               else if (is_glitch) err_d   = 1'b1;
            end
         end
         StBnd: begin
            if (timeout) begin
               eof_d = 1'b1;
            end else if (line_edge) begin
               if (is_short) valid_d = 1'b1;
               else          err_d   = 1'b1;
            end
         end
         default: ;
      endcase
      // falling mid-bit edge decodes as 1
      data_d = valid_d ? ~line_rise : out_data;
   end

   always_ff @(posedge clk or negedge in_enable) begin
      if (!in_enable) begin
         out_data   <= 1'b0;
         out_valid  <= 1'b0;
         out_locked <= 1'b0;
         out_err    <= 1'b0;
         out_eof    <= 1'b0;
      end else begin
         out_data   <= data_d;
         out_valid  <= valid_d;
         out_locked <= (state_d != StHunt);
         out_err    <= err_d;
         out_eof    <= eof_d;
      end
   end

endmodule

// File: tb/tb_man_demod.sv
// Scoreboard bench for man_demod: directed edge sequences push expected strobes with their
// cycle of arrival; a negedge monitor pops and compares every strobe the decoder produces.
module tb_man_demod;

   localparam int KVal  = 0;
   localparam int KErr  = 1;
   localparam int KEof  = 2;
   localparam int KNone = 3;

   typedef struct {
      int kind;
      bit data;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic in_enable;
   logic in_data;
   logic out_data, out_valid, out_locked, out_err, out_eof;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_edge = 0;
   logic prev_locked = 1'b0;
   ev_t  sb[$];

   man_demod #(.OVS(8), .CNT_W(6)) dut (
      .clk       (clk),
      .in_enable (in_enable),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_locked(out_locked),
      .out_err   (out_err),
      .out_eof   (out_eof)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int want);
      n_checks++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Toggle the line; a decoded strobe shows up three clk edges later.
   task automatic flip(input int kind, input bit d);
      ev_t e;
      in_data   = ~in_data;
      last_edge = cyc;
      if (kind != KNone) begin
         e.kind = kind;
         e.data = d;
         e.cyc  = cyc + 3;
         sb.push_back(e);
      end
   endtask

   // Timeout: counter saturates 21 cycles after the last edge is seen.
   task automatic expect_eof();
      ev_t e;
      e.kind = KEof;
      e.data = 1'b0;
      e.cyc  = last_edge + 24;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : mon
      ev_t e;
      int  kind;
      if (!in_enable) begin
         prev_locked = 1'b0;
      end else begin
         chk("exclusive_strobes", int'((out_err & out_eof) | (out_valid & out_err)), 0);
         if (out_valid || out_err || out_eof) begin
            kind = out_valid ? KVal : (out_err ? KErr : KEof);
            if (sb.size() == 0) begin
               chk("unexpected_strobe_kind", kind, -1);
            end else begin
               e = sb.pop_front();
               chk("strobe_kind", kind, e.kind);
               chk("strobe_cycle", cyc, e.cyc);
               chk("strobe_locked", int'(out_locked), int'(kind == KVal));
               if (kind == KVal) chk("bit_data", int'(out_data), int'(e.data));
            end
         end else begin
            chk("locked_steady", int'(out_locked), int'(prev_locked));
         end
         prev_locked = out_locked;
      end
   end

   initial begin
      in_enable = 1'b1;
      in_data   = 1'b0;
      #1 in_enable = 1'b0;

      // 1: reset holds everything low while the line toggles; then idle
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #2 in_data = ~in_data;
         #1 chk("reset_outputs", {out_data, out_valid, out_locked, out_err, out_eof}, 0);
      end
      in_data = 1'b0;
      tick(1);
      in_enable = 1'b1;
      tick(100);
      chk("idle_unlocked", int'(out_locked), 0);

      // 2: bits 1,0,1,1,0,0 from idle low -> 0,1,1,0,0 then eof
      flip(KNone, 0); tick(8);
      flip(KNone, 0); tick(16);
      flip(KVal, 0);  tick(16);
      flip(KVal, 1);  tick(8);
      flip(KNone, 0); tick(8);
      flip(KVal, 1);  tick(16);
      flip(KVal, 0);  tick(8);
      flip(KNone, 0); tick(8);
      flip(KVal, 0);  expect_eof(); tick(40);

      // 3: jittered intervals 4,11,12,20 decode, 3-cycle glitch errors, long edge relocks
      flip(KNone, 0); tick(16);
      flip(KVal, 0);  tick(4);
      flip(KNone, 0); tick(11);
      flip(KVal, 0);  tick(12);
      flip(KVal, 1);  tick(20);
      flip(KVal, 0);  tick(3);
      flip(KErr, 0);  tick(12);
      flip(KVal, 0);  expect_eof(); tick(40);

      // 4: long interval while at a bit boundary is an error with no bit
      flip(KNone, 0); tick(16);
      flip(KVal, 0);  tick(8);
      flip(KNone, 0); tick(14);
      flip(KErr, 0);  tick(40);

      // 5: bits 0,1,0 then a quiet line -> 1,0, a single eof, then silence
      flip(KNone, 0); tick(8);
      flip(KNone, 0); tick(16);
      flip(KVal, 1);  tick(16);
      flip(KVal, 0);  expect_eof(); tick(224);

      // 6: asynchronous reset mid-frame, then a fresh 1,0,1 frame
      flip(KNone, 0); tick(16);
      flip(KVal, 0);  tick(6);
      chk("locked_before_reset", int'(out_locked), 1);
      in_enable = 1'b0;
      #1 chk("async_clear", {out_data, out_valid, out_locked, out_err, out_eof}, 0);
      in_data = 1'b0;
      #9 in_enable = 1'b1;
      tick(30);
      flip(KNone, 0); tick(8);
      flip(KNone, 0); tick(16);
      flip(KVal, 0);  tick(16);
      flip(KVal, 1);  expect_eof(); tick(40);

      tick(10);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
